// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment vectors are [0:6] = a..g, active-low.
package seven_seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_BLANK = 7'b111_1111;
  localparam seg_t SEG_DASH  = 7'b111_1110;

  localparam seg_t SEG_D0 = 7'b000_0001;
  localparam seg_t SEG_D1 = 7'b100_1111;
  localparam seg_t SEG_D2 = 7'b001_0010;
  localparam seg_t SEG_D3 = 7'b000_0110;
  localparam seg_t SEG_D4 = 7'b100_1100;
  localparam seg_t SEG_D5 = 7'b010_0100;
  localparam seg_t SEG_D6 = 7'b010_0000;
  localparam seg_t SEG_D7 = 7'b000_1111;
  localparam seg_t SEG_D8 = 7'b000_0000;
  localparam seg_t SEG_D9 = 7'b000_0100;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low segment lookup.
// Ports: i_bcd - 4-bit digit code; o_seg_c - segments a..g ([0:6]),
//        codes 10..15 map to a dash.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [0:6] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg_c = SEG_D0;
      4'd1:    o_seg_c = SEG_D1;
      4'd2:    o_seg_c = SEG_D2;
      4'd3:    o_seg_c = SEG_D3;
      4'd4:    o_seg_c = SEG_D4;
      4'd5:    o_seg_c = SEG_D5;
      4'd6:    o_seg_c = SEG_D6;
      4'd7:    o_seg_c = SEG_D7;
      4'd8:    o_seg_c = SEG_D8;
      4'd9:    o_seg_c = SEG_D9;
      default: o_seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with ghost blanking,
// leading-zero blanking and a frame-aligned load handshake.
// Ports: clk, reset (async active-low); in_bcd/in_valid/in_ready - load
//        handshake (in_ready is combinational); Seg [0:6] / An [3:0] -
//        registered active-low segment and digit enables; frame_done -
//        registered one-cycle pulse after the last drive cycle of digit 3.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 16,
  parameter int unsigned LZB   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_bcd,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [0:6]  Seg,
  output logic [3:0]  An,
  output logic        frame_done
);

  localparam int unsigned CNT_MAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK - 1);
  localparam logic [CW-1:0] DIV_LOAD   = CW'(DIV - 1);

  state_t          r_state;
  logic [1:0]      r_idx;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_displayed;
  logic [15:0]     r_shadow;
  logic            r_pending;
  logic [0:6]      r_seg;
  logic [3:0]      r_an;
  logic            r_frame_done;

  state_t          w_state_nxt;
  logic [1:0]      w_idx_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_frame_end;
  logic            w_xfer;
  logic [3:0]      w_digit;
  logic [15:0]     w_upper;
  logic            w_lz_blank;
  logic [0:6]      w_seg_dig;
  logic [0:6]      w_seg_nxt;
  logic [3:0]      w_an_nxt;

  assign w_frame_end = (r_state == ST_DRIVE) && (r_idx == 2'd3) && (r_cnt == '0);
  assign w_xfer      = in_valid && !r_pending;
  assign in_ready    = !r_pending;

  // Scan state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_BLANK;
      r_idx   <= 2'd0;
      r_cnt   <= BLANK_LOAD;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: count down each phase, reload on phase change
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt - CW'(1);
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = DIV_LOAD;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_BLANK;
          w_idx_nxt   = r_idx + 2'd1;
          w_cnt_nxt   = BLANK_LOAD;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_idx_nxt   = 2'd0;
        w_cnt_nxt   = BLANK_LOAD;
      end
    endcase
  end

  // Outputs are computed from the next state so the registered pins line
  // up with the state register. r_displayed only changes when the next
  // state is BLANK, so using its current value here is safe.
  assign w_digit    = r_displayed[{w_idx_nxt, 2'b00} +: 4];
  assign w_upper    = r_displayed >> {w_idx_nxt, 2'b00};
  assign w_lz_blank = (LZB != 0) && (w_idx_nxt != 2'd0) && (w_upper == 16'h0000);

  bcd_to_seg u_bcd_to_seg (
    .i_bcd   (w_digit),
    .o_seg_c (w_seg_dig)
  );

  // Output decode
  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_an_nxt  = 4'b1111;
    if ((w_state_nxt == ST_DRIVE) && !w_lz_blank) begin
      w_seg_nxt = w_seg_dig;
      w_an_nxt  = ~(4'b0001 << w_idx_nxt);
    end
  end

  // Registered pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg        <= SEG_BLANK;
      r_an         <= 4'b1111;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  // Load handshake; a transfer and a commit can never coincide since one
  // needs pending clear and the other pending set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow    <= 16'h0000;
      r_displayed <= 16'h0000;
      r_pending   <= 1'b0;
    end else if (w_xfer) begin
      r_shadow  <= in_bcd;
      r_pending <= 1'b1;
    end else if (w_frame_end && r_pending) begin
      r_displayed <= r_shadow;
      r_pending   <= 1'b0;
    end
  end

  assign Seg        = r_seg;
  assign An         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with DIV=4, BLANK=2; two instances differ
// only in leading-zero blanking and share all inputs.
module tb_seven_seg_scan_ctrl;

  localparam int DIVP   = 4;
  localparam int BLANKP = 2;
  localparam int SLOT   = DIVP + BLANKP;
  localparam int FRAME  = 4 * SLOT;

  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010,
                         P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100,
                         P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000,
                         P9 = 7'b0000100, PD = 7'b1111110, PB = 7'b1111111;

  logic        clk;
  logic        reset;
  logic [15:0] in_bcd;
  logic        in_valid;
  logic        rdy_a, rdy_b, fd_a, fd_b;
  logic [0:6]  seg_a, seg_b;
  logic [3:0]  an_a, an_b;

  seven_seg_scan_ctrl #(.DIV(DIVP), .BLANK(BLANKP), .LZB(1)) dut_a (
    .clk(clk), .reset(reset), .in_bcd(in_bcd), .in_valid(in_valid),
    .in_ready(rdy_a), .Seg(seg_a), .An(an_a), .frame_done(fd_a));

  seven_seg_scan_ctrl #(.DIV(DIVP), .BLANK(BLANKP), .LZB(0)) dut_b (
    .clk(clk), .reset(reset), .in_bcd(in_bcd), .in_valid(in_valid),
    .in_ready(rdy_b), .Seg(seg_b), .An(an_b), .frame_done(fd_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: cycles since reset release plus the visible/queued values
  int          t;
  logic [15:0] m_disp, m_shadow;
  bit          m_pend;

  typedef struct packed {
    logic [15:0]      bcd;
    logic [3:0][6:0]  e1;   // expected Seg per digit with LZB=1 (digit3 first)
    logic [3:0][6:0]  e0;   // expected Seg per digit with LZB=0
  } vec_t;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s t=%0d got %h expected %h", nm, t, act, exp);
    else n_pass++;
  endtask

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return P0; 4'd1: return P1; 4'd2: return P2; 4'd3: return P3;
      4'd4: return P4; 4'd5: return P5; 4'd6: return P6; 4'd7: return P7;
      4'd8: return P8; 4'd9: return P9;
      default: return PD;
    endcase
  endfunction

  task automatic exp_out(input int lzb, output logic [6:0] s, output logic [3:0] a);
    int pos, slot;
    logic [15:0] up;
    pos  = t % FRAME;
    slot = pos / SLOT;
    s = PB;
    a = 4'hF;
    if ((pos % SLOT) >= BLANKP) begin
      up = m_disp >> (4 * slot);
      if (!(lzb != 0 && slot > 0 && up == 16'h0)) begin
        s = pat(up[3:0]);
        a = 4'hF ^ (4'(1) << slot);
      end
    end
  endtask

  task automatic model_reset();
    t = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 1'b0;
  endtask

  // One clock: advance the model with the inputs the DUT is about to sample,
  // then compare every output shortly after the edge.
  task automatic step();
    logic [6:0] s;
    logic [3:0] a;
    if ((t % FRAME) == FRAME - 1 && m_pend) begin
      m_disp = m_shadow; m_pend = 1'b0;
    end else if (in_valid && !m_pend) begin
      m_shadow = in_bcd; m_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    t++;
    exp_out(1, s, a);
    chk("seg_lzb1", 16'(seg_a), 16'(s));
    chk("an_lzb1", 16'(an_a), 16'(a));
    exp_out(0, s, a);
    chk("seg_lzb0", 16'(seg_b), 16'(s));
    chk("an_lzb0", 16'(an_b), 16'(a));
    chk("frame_done", 16'({fd_b, fd_a}), ((t % FRAME) == 0) ? 16'h3 : 16'h0);
    chk("in_ready", 16'({rdy_b, rdy_a}), m_pend ? 16'h0 : 16'h3);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100; i++) begin
      if (rdy_a) return;
      step();
    end
    n_total++;
    $display("FAIL wait_ready timeout t=%0d", t);
  endtask

  task automatic load(input logic [15:0] v);
    wait_ready();
    in_valid = 1'b1; in_bcd = v;
    step();
    in_valid = 1'b0; in_bcd = 16'($urandom);
  endtask

  task automatic check_pins_reset(input string nm);
    chk({nm, "_an"}, 16'({an_b, an_a}), 16'hFF);
    chk({nm, "_seg"}, 16'({seg_b, seg_a}), 16'h3FFF);
    chk({nm, "_fd"}, 16'({fd_b, fd_a}), 16'h0);
    chk({nm, "_rdy"}, 16'({rdy_b, rdy_a}), 16'h3);
  endtask

  vec_t vecs [8];

  initial begin
    bit ok;
    logic [15:0] v;

    vecs[0] = '{16'h1234, {P1, P2, P3, P4}, {P1, P2, P3, P4}};
    vecs[1] = '{16'h00A5, {PB, PB, PD, P5}, {P0, P0, PD, P5}};
    vecs[2] = '{16'h0007, {PB, PB, PB, P7}, {P0, P0, P0, P7}};
    vecs[3] = '{16'h0000, {PB, PB, PB, P0}, {P0, P0, P0, P0}};
    vecs[4] = '{16'h9F08, {P9, PD, P0, P8}, {P9, PD, P0, P8}};
    vecs[5] = '{16'h0B00, {PB, PD, P0, P0}, {P0, PD, P0, P0}};
    vecs[6] = '{16'h5678, {P5, P6, P7, P8}, {P5, P6, P7, P8}};
    vecs[7] = '{16'hE000, {PD, P0, P0, P0}, {PD, P0, P0, P0}};

    reset = 1'b0; in_valid = 1'b0; in_bcd = 16'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_pins_reset("reset");
    @(negedge clk);
    reset = 1'b1;

    // Idle frames: only digit0 '0' visible, frame_done every FRAME cycles
    repeat (2 * FRAME + 4) step();

    // Mid-frame load must wait for the frame boundary
    while ((t % FRAME) != 5) step();
    load(16'h1234);
    repeat (FRAME + 30) step();

    // Back-to-back loads: the second stalls until the cycle after commit
    load(16'h1111);
    in_valid = 1'b1; in_bcd = 16'h2222;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rdy_a) begin
        chk("ready_returns_at_frame_done", 16'(fd_a), 16'h1);
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin n_total++; $display("FAIL stall_release timeout t=%0d", t); end
    in_valid = 1'b0;
    repeat (2 * FRAME + 3) step();

    // Table of digit patterns, read mid-drive in each slot after commit
    foreach (vecs[n]) begin
      load(vecs[n].bcd);
      ok = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
        step();
        if (fd_a) begin ok = 1'b1; break; end
      end
      if (!ok) begin n_total++; $display("FAIL frame_done timeout t=%0d", t); end
      for (int k = 0; k < 4; k++) begin
        repeat ((k == 0) ? BLANKP + 1 : SLOT) step();
        chk("vec_seg_lzb1", 16'(seg_a), 16'(vecs[n].e1[k]));
        chk("vec_an_lzb1", 16'(an_a), (vecs[n].e1[k] == PB) ? 16'hF : 16'(4'hF ^ (4'(1) << k)));
        chk("vec_seg_lzb0", 16'(seg_b), 16'(vecs[n].e0[k]));
        chk("vec_an_lzb0", 16'(an_b), 16'(4'hF ^ (4'(1) << k)));
      end
    end

    // Reset on the second drive cycle of digit2 while a load is pending
    while ((t % FRAME) != 1) step();
    load(16'h8888);
    while ((t % FRAME) != 2 * SLOT + BLANKP + 1) step();
    chk("pending_before_reset", 16'(rdy_a), 16'h0);
    reset = 1'b0;
    #1;
    check_pins_reset("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (BLANKP + 1) step();
    chk("post_reset_d0_seg", 16'(seg_a), 16'(P0));
    chk("post_reset_d0_an", 16'(an_a), 16'hE);
    repeat (SLOT) step();
    chk("post_reset_d1_an", 16'(an_a), 16'hF);
    repeat (FRAME) step();

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 4; k++)
        v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      in_bcd = v;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter DIV, 1000, clock cycles each digit is driven per scan slot; SHALL be >= 1.
REQ-002 Parameter BLANK, 16, clock cycles of all-off ghost-suppression before each digit slot; SHALL be >= 1.
REQ-003 Parameter LZB, 1, leading-zero blanking enable (1 = on).
REQ-004 Port list, in this order:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_bcd  input  16  four BCD digits; [3:0] = digit0 (rightmost), [15:12] = digit3.
- in_valid  input  1  in_bcd offered.
- in_ready  output  1  controller can accept in_bcd.
- Seg  output  [0:6]  active-low segments; Seg[0] = a … Seg[6] = g.
- An  output  4  active-low digit enables; An[k] selects digit k.
- frame_done  output  1  one-cycle pulse at the end of each 4-digit scan.

Function
REQ-005 States SHALL be BLANK and DRIVE, with a 2-bit digit index idx and a down-counter sized for max(DIV, BLANK).
REQ-006 BLANK SHALL last exactly BLANK cycles with An = 4'b1111 and Seg = 7'b111_1111, then go to DRIVE.
REQ-007 DRIVE SHALL last exactly DIV cycles with An = ~(1 << idx) and Seg = pattern of the displayed digit idx, then go to BLANK with idx = (idx + 1) mod 4.
REQ-008 The frame period SHALL be exactly 4*(BLANK+DIV) cycles; Seg and An SHALL be register outputs with no glitches.
REQ-009 Segment patterns (a..g, active-low) SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-010 Digit codes 10–15 SHALL display a dash, 7'b111_1110; such a digit does not count as zero.
REQ-011 With LZB = 1, digit k (k = 3..1) SHALL be blanked when it and all higher digits equal 0: An stays 4'b1111 and Seg = 7'b111_1111 for that slot, with slot timing unchanged. Digit0 is never blanked.
REQ-012 Handshake: a transfer occurs when in_valid && in_ready; in_bcd is latched into a shadow register and pending is set.
REQ-013 in_ready SHALL equal !pending (combinational); in_bcd need not be held after the transfer cycle.
REQ-014 The displayed register SHALL update only at a frame boundary, i.e. the last DRIVE cycle of idx = 3: if pending, displayed <= shadow and pending clears. No mid-frame tearing.
REQ-015 frame_done SHALL pulse high for the cycle following the last DRIVE cycle of idx = 3, every frame, independent of pending.
REQ-016 in_valid held high while in_ready = 0 SHALL NOT be accepted; it is accepted on the first cycle in_ready returns high (the cycle after commit).

Reset
REQ-017 reset low SHALL immediately force An = 4'b1111, Seg = 7'b111_1111 and frame_done = 0, and clear pending (in_ready = 1).
REQ-018 Reset SHALL also set state = BLANK, idx = 0, displayed = 16'h0000, shadow = 16'h0000 and the counter to its BLANK load value.
REQ-019 Reset asserted mid-DRIVE or mid-handshake SHALL discard any pending value; the first post-reset frame starts with a full BLANK period.

Structure
REQ-020 The shared package seven_seg_pkg SHALL hold SEG_BLANK, SEG_DASH, the ten digit patterns and the state enum.
REQ-021 The combinational digit-to-segment lookup SHALL be the sub-module bcd_to_seg (4-bit in, [0:6] out); all sequencing stays in seven_seg_scan_ctrl.

Verification (DIV = 4, BLANK = 2)
REQ-022 Release reset, no load: the frame shows An = 1110 with Seg = 0000001 for 4 cycles; slots 1–3 show An = 1111; the frame_done period is 24 cycles.
REQ-023 Load 16'h1234 mid-frame: it is not displayed until the next frame; then digit0 shows 1001100 (An = 1110), digit1 0000110, digit2 0010010, digit3 1001111.
REQ-024 Two back-to-back valids of 16'h1111 then 16'h2222: the second is stalled (in_ready = 0) until one cycle after the commit; 2222 appears one frame after 1111.
REQ-025 Load 16'h00A5: digit0 shows 0100100, digit1 shows the dash 1111110, digits 2–3 are blanked; with LZB = 0 and 16'h0007 the display shows 0000001, 0000001, 0000001, 0001111 for digits 3..0.
REQ-026 Assert reset on the 2nd DRIVE cycle of digit2 with a pending load: An = 1111 asynchronously, in_ready = 1, and the display shows 0000 (digit0 only) after release.
